// File: rtl/video_timing_meas_pkg.sv
// Shared types and constants for the video timing measurement block.
package video_timing_meas_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned MATCH_W = 4;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(4095);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] v_total;
        logic [CNT_W-1:0] v_active;
    } meas_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/video_timing_meas_sync_edge_det.sv
// Registers a sync input normalised to "asserted" and flags its start edge.
module sync_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_i,
    output logic start_o
);

    logic lvl_q;
    logic prev_q;
    logic start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            lvl_q   <= (sync_i == POL);
            prev_q  <= lvl_q;
            start_q <= lvl_q & ~prev_q;
        end
    end

    assign start_o = start_q;

endmodule

// File: rtl/video_timing_meas.sv
// Measures line/frame geometry of an incoming sync stream and tracks lock.
module video_timing_meas
    import video_timing_meas_pkg::*;
#(
    parameter logic        HS_POL      = 1'b1,
    parameter logic        VS_POL      = 1'b1,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned FCNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [15:0]      frame_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             timing_err
);

    logic hs_start;
    logic vs_start;

    sync_edge_det #(.POL(HS_POL)) u_hs_det (
        .clk     (clk),
        .rst     (rst),
        .sync_i  (hs),
        .start_o (hs_start)
    );

    sync_edge_det #(.POL(VS_POL)) u_vs_det (
        .clk     (clk),
        .rst     (rst),
        .sync_i  (vs),
        .start_o (vs_start)
    );

    logic             de_q;
    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] de_cnt_q, de_cnt_d;
    logic [CNT_W-1:0] h_tot_lat_q, h_tot_lat_d;
    logic [CNT_W-1:0] h_act_lat_q, h_act_lat_d;
    logic [CNT_W-1:0] lines_q, lines_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic             frame_sat_q, frame_sat_d;

    logic [CNT_W-1:0] de_now_c;
    logic [CNT_W-1:0] lines_now_c;
    logic [CNT_W-1:0] act_now_c;
    logic             line_act_c;
    logic             sat_now_c;
    meas_t            new_c;

    // Closing values include the current cycle so a coincident hs start lands in the closing frame.
    // h_active follows the most recent line that carried de, so blanking lines do not zero it.
    always_comb begin
        de_now_c    = de_q ? sat_inc(de_cnt_q) : de_cnt_q;
        line_act_c  = hs_start && (de_now_c != '0);
        lines_now_c = hs_start ? sat_inc(lines_q) : lines_q;
        act_now_c   = line_act_c ? sat_inc(act_q) : act_q;

        new_c.h_total  = hs_start ? pix_q : h_tot_lat_q;
        new_c.h_active = line_act_c ? de_now_c : h_act_lat_q;
        new_c.v_total  = lines_now_c;
        new_c.v_active = act_now_c;

        sat_now_c = frame_sat_q || (pix_q == CNT_SAT) || (de_now_c == CNT_SAT)
                 || (lines_now_c == CNT_SAT) || (act_now_c == CNT_SAT);

        pix_d       = hs_start ? CNT_W'(1) : sat_inc(pix_q);
        de_cnt_d    = hs_start ? '0 : de_now_c;
        h_tot_lat_d = new_c.h_total;
        h_act_lat_d = vs_start ? '0 : new_c.h_active;
        lines_d     = vs_start ? '0 : lines_now_c;
        act_d       = vs_start ? '0 : act_now_c;
        frame_sat_d = vs_start ? 1'b0 : sat_now_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q        <= 1'b0;
            pix_q       <= '0;
            de_cnt_q    <= '0;
            h_tot_lat_q <= '0;
            h_act_lat_q <= '0;
            lines_q     <= '0;
            act_q       <= '0;
            frame_sat_q <= 1'b0;
        end else begin
            de_q        <= de;
            pix_q       <= pix_d;
            de_cnt_q    <= de_cnt_d;
            h_tot_lat_q <= h_tot_lat_d;
            h_act_lat_q <= h_act_lat_d;
            lines_q     <= lines_d;
            act_q       <= act_d;
            frame_sat_q <= frame_sat_d;
        end
    end

    state_e             state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MATCH_W-1:0] match_inc_c;
    logic               equal_c;
    meas_t              stored_q, stored_d;
    meas_t              out_q, out_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               mv_q, mv_d;
    logic               locked_q, locked_d;
    logic               te_q, te_d;

    // Lock tracking; a saturated frame never compares equal.
    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        stored_d    = stored_q;
        out_d       = out_q;
        fcnt_d      = fcnt_q;
        mv_d        = 1'b0;
        locked_d    = locked_q;
        te_d        = 1'b0;
        match_inc_c = match_q + MATCH_W'(1);
        equal_c     = (new_c == stored_q) && !sat_now_c;

        if (vs_start) begin
            case (state_q)
                ST_SEARCH: begin
                    state_d = ST_MEASURE;
                end
                ST_MEASURE: begin
                    stored_d = new_c;
                    out_d    = new_c;
                    mv_d     = 1'b1;
                    match_d  = '0;
                    fcnt_d   = fcnt_q + FCNT_W'(1);
                    state_d  = ST_CHECK;
                end
                ST_CHECK: begin
                    out_d  = new_c;
                    mv_d   = 1'b1;
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    if (equal_c) begin
                        match_d = match_inc_c;
                        if (match_inc_c >= MATCH_W'(LOCK_FRAMES)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        stored_d = new_c;
                        match_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    out_d  = new_c;
                    mv_d   = 1'b1;
                    fcnt_d = fcnt_q + FCNT_W'(1);
                    if (!equal_c) begin
                        te_d     = 1'b1;
                        locked_d = 1'b0;
                        stored_d = new_c;
                        match_d  = '0;
                        state_d  = ST_CHECK;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            match_q  <= '0;
            stored_q <= '0;
            out_q    <= '0;
            fcnt_q   <= '0;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            te_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            stored_q <= stored_d;
            out_q    <= out_d;
            fcnt_q   <= fcnt_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            te_q     <= te_d;
        end
    end

    assign h_total    = out_q.h_total;
    assign h_active   = out_q.h_active;
    assign v_total    = out_q.v_total;
    assign v_active   = out_q.v_active;
    assign frame_cnt  = 16'(fcnt_q);
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timing_err = te_q;

endmodule

// File: tb/tb_video_timing_meas.sv
// Directed bench: a small sync generator drives three instances (normal, inverted, narrow frame counter).
module tb_video_timing_meas;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hs_a, vs_a, hs_b, vs_b, de;
    logic [11:0] ht_a, ha_a, vt_a, va_a, ht_b, ha_b, vt_b, va_b, ht_w, ha_w, vt_w, va_w;
    logic [15:0] fc_a, fc_b, fc_w;
    logic mv_a, lk_a, te_a, mv_b, lk_b, te_b, mv_w, lk_w, te_w;

    video_timing_meas dut_a (
        .clk(clk), .rst(rst), .hs(hs_a), .vs(vs_a), .de(de),
        .h_total(ht_a), .h_active(ha_a), .v_total(vt_a), .v_active(va_a),
        .frame_cnt(fc_a), .meas_valid(mv_a), .locked(lk_a), .timing_err(te_a)
    );

    video_timing_meas #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .hs(hs_b), .vs(vs_b), .de(de),
        .h_total(ht_b), .h_active(ha_b), .v_total(vt_b), .v_active(va_b),
        .frame_cnt(fc_b), .meas_valid(mv_b), .locked(lk_b), .timing_err(te_b)
    );

    video_timing_meas #(.FCNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .hs(hs_a), .vs(vs_a), .de(de),
        .h_total(ht_w), .h_active(ha_w), .v_total(vt_w), .v_active(va_w),
        .frame_cnt(fc_w), .meas_valid(mv_w), .locked(lk_w), .timing_err(te_w)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    int hact = 40, gx = 0, gy = 5, vs_starts = 0, last_vs = 0, te_cnt = 0;
    bit gen_on = 1'b0, gen_long = 1'b0;
    bit hs_act, vs_act;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One pixel: sample pulse outputs, then drive the generator (sync at x 0..1, active from x 4).
    task automatic step();
        int len;
        @(negedge clk);
        cyc++;
        if (te_a) te_cnt++;
        if (gen_on) begin
            len    = hact + 6 + ((gen_long && gy == 5) ? 5000 : 0);
            hs_act = (gx < 2);
            vs_act = (gy == 6 || gy == 7);
            de     = (gy < 4) && (gx >= 4) && (gx < 4 + hact);
            if (gy == 6 && gx == 0) begin
                vs_starts++;
                last_vs = cyc;
            end
            gx++;
            if (gx == len) begin
                gx = 0;
                gy = (gy == 9) ? 0 : gy + 1;
            end
        end else begin
            hs_act = 1'b0;
            vs_act = 1'b0;
            de     = 1'b0;
        end
        hs_a = hs_act;
        vs_a = vs_act;
        hs_b = ~hs_act;
        vs_b = ~vs_act;
    endtask

    task automatic wait_mv(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mv_a && n < budget);
        chk({tag, "_mv"}, 32'(mv_a), 1);
    endtask

    initial begin
        rst = 1'b1; hs_a = 1'b0; vs_a = 1'b0; hs_b = 1'b1; vs_b = 1'b1; de = 1'b0;
        repeat (3) step();
        chk("rst_ht", 32'(ht_a), 0);
        chk("rst_fc", 32'(fc_a), 0);
        chk("rst_mv", 32'(mv_a), 0);
        chk("rst_lk", 32'(lk_a), 0);

        // Full-width stream, first measurement and its latency.
        hact = 1920; gx = 0; gy = 5; gen_on = 1'b1; rst = 1'b0;
        wait_mv(30000, "a1");
        chk("a1_latency", 32'(cyc - last_vs), 3);
        chk("a1_ht", 32'(ht_a), 1926);
        chk("a1_ha", 32'(ha_a), 1920);
        chk("a1_vt", 32'(vt_a), 10);
        chk("a1_va", 32'(va_a), 4);
        chk("a1_fc", 32'(fc_a), 1);
        chk("a1_lk", 32'(lk_a), 0);
        chk("a1_b_mv", 32'(mv_b), 1);
        chk("a1_b_ht", 32'(ht_b), 1926);
        chk("a1_b_ha", 32'(ha_b), 1920);
        chk("a1_b_vt", 32'(vt_b), 10);
        chk("a1_b_va", 32'(va_b), 4);
        step();
        chk("a1_pulse", 32'(mv_a), 0);
        chk("a1_hold", 32'(ht_a), 1926);

        // Narrow stream from reset: lock at the third measurement.
        rst = 1'b1; gen_on = 1'b0;
        repeat (2) step();
        rst = 1'b0; hact = 40; gx = 0; gy = 5; gen_on = 1'b1;
        wait_mv(2000, "b1");
        chk("b1_ht", 32'(ht_a), 46);
        chk("b1_ha", 32'(ha_a), 40);
        chk("b1_lk", 32'(lk_a), 0);
        wait_mv(1000, "b2");
        chk("b2_lk", 32'(lk_a), 0);
        chk("b2_fc", 32'(fc_a), 2);
        wait_mv(1000, "b3");
        chk("b3_lk", 32'(lk_a), 1);
        chk("b3_fc", 32'(fc_a), 3);
        chk("b3_b_mv", 32'(mv_b), 1);
        chk("b3_b_lk", 32'(lk_b), 1);
        chk("b3_b_fc", 32'(fc_b), 3);
        chk("b3_te_cnt", 32'(te_cnt), 0);

        // Geometry change while locked.
        hact = 20;
        wait_mv(1000, "c1");
        chk("c1_te", 32'(te_a), 1);
        chk("c1_lk", 32'(lk_a), 0);
        chk("c1_ht", 32'(ht_a), 26);
        chk("c1_ha", 32'(ha_a), 20);
        chk("c1_vt", 32'(vt_a), 10);
        chk("c1_va", 32'(va_a), 4);
        chk("c1_b_te", 32'(te_b), 1);
        wait_mv(1000, "c2");
        chk("c2_lk", 32'(lk_a), 0);
        wait_mv(1000, "c3");
        chk("c3_lk", 32'(lk_a), 1);
        chk("c3_te_cnt", 32'(te_cnt), 1);

        // Narrow frame counter wraps 7 -> 0.
        wait_mv(1000, "f7");
        chk("f7_fc_w", 32'(fc_w), 7);
        wait_mv(1000, "f8");
        chk("f8_fc_w", 32'(fc_w), 0);
        chk("f8_fc_a", 32'(fc_a), 8);
        chk("f8_lk", 32'(lk_a), 1);
        chk("f8_w_mv", 32'(mv_w), 1);
        chk("f8_w_lk", 32'(lk_w), 1);
        chk("f8_w_ht", 32'(ht_w), 26);
        chk("f8_w_ha", 32'(ha_w), 20);
        chk("f8_w_vt", 32'(vt_w), 10);
        chk("f8_w_va", 32'(va_w), 4);
        chk("f8_w_te", 32'(te_w), 0);
        chk("f8_te_cnt", 32'(te_cnt), 1);

        // Reset mid-frame while locked.
        repeat (100) step();
        chk("d_pre_lk", 32'(lk_a), 1);
        rst = 1'b1;
        step();
        chk("d_rst_ht", 32'(ht_a), 0);
        chk("d_rst_ha", 32'(ha_a), 0);
        chk("d_rst_vt", 32'(vt_a), 0);
        chk("d_rst_va", 32'(va_a), 0);
        chk("d_rst_fc", 32'(fc_a), 0);
        chk("d_rst_lk", 32'(lk_a), 0);
        step();
        rst = 1'b0; vs_starts = 0;
        wait_mv(1000, "d1");
        chk("d1_vs_starts", 32'(vs_starts), 2);
        chk("d1_latency", 32'(cyc - last_vs), 3);
        chk("d1_ht", 32'(ht_a), 26);
        chk("d1_fc", 32'(fc_a), 1);

        // One over-long line per frame: h_total saturates, never locks, no error pulse.
        gen_long = 1'b1;
        wait_mv(8000, "e1");
        chk("e1_ht", 32'(ht_a), 4095);
        chk("e1_ha", 32'(ha_a), 20);
        chk("e1_lk", 32'(lk_a), 0);
        wait_mv(8000, "e2");
        chk("e2_ht", 32'(ht_a), 4095);
        chk("e2_lk", 32'(lk_a), 0);
        wait_mv(8000, "e3");
        chk("e3_lk", 32'(lk_a), 0);
        chk("e3_te_cnt", 32'(te_cnt), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
